gate_bist_checker: RTL



---
 rtl/gate_bist_pkg.sv | 13 +
 rtl/gate_bist_checker_if.sv | 28 ++
 rtl/gate_bist_vec_gen.sv | 40 ++++
 rtl/gate_bist_checker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types for the gate BIST checker: run-sequencer states.
package gate_bist_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gate_bist_checker_if.sv
// Signal bundle between the BIST checker (master) and its gate-under-test / controller (slave).
interface gate_bist_checker_if #(
    parameter int N_IN = 2
);
    localparam int NV = 2 ** N_IN;

    logic            start;
    logic [NV-1:0]   truth_table;
    logic [N_IN-1:0] gut_in;
    logic            gut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_count;
    logic            first_fail_valid;
    logic [N_IN-1:0] first_fail_vec;

    modport master (
        input  start, truth_table, gut_out,
        output gut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        output start, truth_table, gut_out,
        input  gut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
    );

endinterface

// File: rtl/gate_bist_vec_gen.sv
// Input-vector counter for the gate under test: clear, increment, and last-vector flag.
module gate_bist_vec_gen #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [N_IN-1:0] vec,
    output logic            last
);

    logic [N_IN-1:0] vec_d;
    logic [N_IN-1:0] vec_q;

    // Next vector: clear has priority, no wrap is ever requested by the sequencer
    always_comb begin
        vec_d = vec_q;
        if (clr) begin
            vec_d = {N_IN{1'b0}};
        end else if (inc) begin
            vec_d = vec_q + N_IN'(1);
        end else begin
            vec_d = vec_q;
        end
    end

    // Vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= {N_IN{1'b0}};
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec  = vec_q;
    assign last = (vec_q == {N_IN{1'b1}});

endmodule

// File: rtl/gate_bist_checker.sv
// Built-in self-test for a combinational gate: sweeps all input vectors, compares the
// gate output against a latched truth table and reports pass, mismatch count and first failure.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    gate_bist_checker_if.master bus
);

    localparam int NV   = 2 ** N_IN;
    localparam int FC_W = N_IN + 1;
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e          state_d, state_q;
    logic [NV-1:0]   tt_d, tt_q;
    logic [SW-1:0]   settle_d, settle_q;
    logic            busy_d, busy_q;
    logic            done_d, done_q;
    logic            pass_d, pass_q;
    logic [FC_W-1:0] fail_count_d, fail_count_q;
    logic            ff_valid_d, ff_valid_q;
    logic [N_IN-1:0] ff_vec_d, ff_vec_q;

    logic            vec_clr_s;
    logic            vec_inc_s;
    logic [N_IN-1:0] vec_s;
    logic            last_s;
    logic            mismatch_s;

    gate_bist_vec_gen #(.N_IN(N_IN)) u_vec_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (vec_clr_s),
        .inc  (vec_inc_s),
        .vec  (vec_s),
        .last (last_s)
    );

    // Response compare; an unknown gate output falls to the mismatch branch
    always_comb begin
        mismatch_s = 1'b1;
        if (bus.gut_out == tt_q[vec_s]) begin
            mismatch_s = 1'b0;
        end else begin
            mismatch_s = 1'b1;
        end
    end

    // Run sequencer: next state, result updates and vector-counter control
    always_comb begin
        state_d      = state_q;
        tt_d         = tt_q;
        settle_d     = settle_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        ff_valid_d   = ff_valid_q;
        ff_vec_d     = ff_vec_q;
        vec_clr_s    = 1'b0;
        vec_inc_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_APPLY;
                    tt_d         = bus.truth_table;
                    settle_d     = {SW{1'b0}};
                    pass_d       = 1'b0;
                    fail_count_d = {FC_W{1'b0}};
                    ff_valid_d   = 1'b0;
                    ff_vec_d     = {N_IN{1'b0}};
                    vec_clr_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d  = ST_CHECK;
                    settle_d = {SW{1'b0}};
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    fail_count_d = fail_count_q + FC_W'(1);
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = vec_s;
                    end else begin
                        ff_valid_d = ff_valid_q;
                    end
                end else begin
                    fail_count_d = fail_count_q;
                end
                // Pass must already include a mismatch found on the final vector
                if (last_s) begin
                    state_d = ST_DONE;
                    pass_d  = (fail_count_d == {FC_W{1'b0}});
                end else begin
                    state_d   = ST_APPLY;
                    settle_d  = {SW{1'b0}};
                    vec_inc_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_APPLY) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tt_q         <= {NV{1'b0}};
            settle_q     <= {SW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= {FC_W{1'b0}};
            ff_valid_q   <= 1'b0;
            ff_vec_q     <= {N_IN{1'b0}};
        end else begin
            state_q      <= state_d;
            tt_q         <= tt_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            ff_valid_q   <= ff_valid_d;
            ff_vec_q     <= ff_vec_d;
        end
    end

    assign bus.gut_in           = vec_s;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.fail_count       = fail_count_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;

endmodule
